seg_scan_decoder: RTL

- Reads back a multiplexed 4-digit 7-segment display bus (4-bit active-low digit select, 8-bit segment bus) and rebuilds the four displayed BCD digits. This is the decode counterpart of the clock's display scan encoder.
- Sits on the board-level display nets beside the clock, or in the testbench.
- Gives firmware and self-checks a coherent snapshot of the displayed time, one complete frame at a time.

---
 rtl/seg_scan_pkg.sv | 42 ++++
 rtl/seg_scan_decoder_seg7_to_bcd.sv | 30 +++
 rtl/seg_scan_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scan decoder.
//   - SEG_0..SEG_9, SEG_BLANK : 7-bit gfedcba patterns, active-high
//   - CODE_BLANK, CODE_ERR    : non-BCD codes reported per digit
//   - sel_to_idx()            : active-low one-hot digit select to index
package seg_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef struct packed {
        logic       valid;  // exactly one select line low
        logic [1:0] idx;    // digit position, 0 = rightmost
    } sel_dec_t;

    // 1111 (blanking gap) and multi-digit selects are reported as invalid.
    function automatic sel_dec_t sel_to_idx(input logic [3:0] sel);
        sel_dec_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (sel)
            4'b1110: r.idx = 2'd0;
            4'b1101: r.idx = 2'd1;
            4'b1011: r.idx = 2'd2;
            4'b0111: r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_bcd.sv
// Combinational 7-segment pattern to digit code.
//   seg  : gfedcba pattern, active-high
//   code : 0-9 for a recognised digit, CODE_BLANK for all-off,
//          CODE_ERR for anything else
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_ERR;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_ERR;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the four displayed digits from a multiplexed 7-segment bus.
//   clk, rst       : clock, asynchronous active-high reset
//   sel_seg_i      : active-low digit select (1110 = digit 0, 0111 = digit 3)
//   seg_led_i      : {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   digits_o       : {d3,d2,d1,d0} codes (0-9, F = blank, E = unrecognised)
//   dp_o           : decimal point per digit, active-high
//   frame_valid_o  : one-cycle pulse when digits_o/dp_o take a new frame
//   seg_err_o      : sticky per-digit unrecognised-pattern flag
//   stale_o        : no capture for TIMEOUT_CYC cycles
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYC     = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int TIMEOUT_CYC    = 216000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sel_seg_i,
    input  logic [7:0]  seg_led_i,
    output logic [15:0] digits_o,
    output logic [3:0]  dp_o,
    output logic        frame_valid_o,
    output logic [3:0]  seg_err_o,
    output logic        stale_o
);

    localparam logic [7:0]  CAP_CNT = 8'(STABLE_CYC - 1);
    localparam logic [17:0] TO_MAX  = 18'(TIMEOUT_CYC);

    logic [3:0]  sel_meta_reg, sel_sync_reg, sel_prev_reg;
    logic [7:0]  seg_meta_reg, seg_sync_reg, seg_prev_reg;
    logic [7:0]  stab_cnt_reg, stab_cnt_next;
    logic        cap_flag_reg, cap_flag_next;
    logic [3:0]  seen_reg, seen_next;
    logic [17:0] to_cnt_reg, to_cnt_next;
    logic        frame_valid_reg;

    logic [7:0]  seg_norm;
    logic [3:0]  code;
    sel_dec_t    sel_dec;
    logic        same;
    logic        capture;
    logic        commit;
    logic [3:0]  cap_mask;

    // Two-flop synchronisers plus the previous-cycle copy used for the
    // stability comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_meta_reg <= '0;
            sel_sync_reg <= '0;
            sel_prev_reg <= '0;
            seg_meta_reg <= '0;
            seg_sync_reg <= '0;
            seg_prev_reg <= '0;
        end else begin
            sel_meta_reg <= sel_seg_i;
            sel_sync_reg <= sel_meta_reg;
            sel_prev_reg <= sel_sync_reg;
            seg_meta_reg <= seg_led_i;
            seg_sync_reg <= seg_meta_reg;
            seg_prev_reg <= seg_sync_reg;
        end
    end

    assign seg_norm = SEG_ACTIVE_LOW ? ~seg_sync_reg : seg_sync_reg;

    seg7_to_bcd u_seg7_to_bcd (
        .seg  (seg_norm[6:0]),
        .code (code)
    );

    always_comb begin
        same          = (sel_sync_reg == sel_prev_reg) && (seg_sync_reg == seg_prev_reg);
        stab_cnt_next = 8'd0;
        if (same) begin
            stab_cnt_next = (stab_cnt_reg == 8'hFF) ? 8'hFF : stab_cnt_reg + 8'd1;
        end
        sel_dec = sel_to_idx(sel_sync_reg);
        // The counter value being loaded this cycle is the number of
        // cycles the bus has already matched, so hitting STABLE_CYC-1 here
        // means STABLE_CYC identical samples.
        capture  = same && !cap_flag_reg && sel_dec.valid && (stab_cnt_next == CAP_CNT);
        cap_mask = capture ? (4'b0001 << sel_dec.idx) : 4'b0000;
        cap_flag_next = same ? (cap_flag_reg | capture) : 1'b0;

        commit = (seen_reg == 4'b1111);
        // A capture in the commit cycle starts the next frame.
        seen_next = (commit ? 4'b0000 : seen_reg) | cap_mask;

        to_cnt_next = to_cnt_reg;
        if (capture) begin
            to_cnt_next = 18'd0;
        end else if (to_cnt_reg != TO_MAX) begin
            to_cnt_next = to_cnt_reg + 18'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt_reg    <= 8'd0;
            cap_flag_reg    <= 1'b0;
            seen_reg        <= 4'b0000;
            to_cnt_reg      <= 18'd0;
            frame_valid_reg <= 1'b0;
        end else begin
            stab_cnt_reg    <= stab_cnt_next;
            cap_flag_reg    <= cap_flag_next;
            seen_reg        <= seen_next;
            to_cnt_reg      <= to_cnt_next;
            frame_valid_reg <= commit;
        end
    end

    // Per-digit shadow, output and sticky error registers.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] shadow_code_reg;
            logic       shadow_dp_reg;
            logic [3:0] out_code_reg;
            logic       out_dp_reg;
            logic       err_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_code_reg <= CODE_BLANK;
                    shadow_dp_reg   <= 1'b0;
                    out_code_reg    <= CODE_BLANK;
                    out_dp_reg      <= 1'b0;
                    err_reg         <= 1'b0;
                end else begin
                    if (cap_mask[gi]) begin
                        shadow_code_reg <= code;
                        shadow_dp_reg   <= seg_norm[7];
                        if (code == CODE_ERR) begin
                            err_reg <= 1'b1;
                        end
                    end
                    if (commit) begin
                        out_code_reg <= shadow_code_reg;
                        out_dp_reg   <= shadow_dp_reg;
                    end
                end
            end

            assign digits_o[gi*4 +: 4] = out_code_reg;
            assign dp_o[gi]            = out_dp_reg;
            assign seg_err_o[gi]       = err_reg;
        end
    endgenerate

    assign frame_valid_o = frame_valid_reg;
    assign stale_o       = (to_cnt_reg == TO_MAX);

endmodule
